// File: rtl/paint_pkg.sv
// Shared types and constants for the paint controller slice.
//   paint_state_t : sequencer states (IDLE, PAINT, CLEAR)
//   color_t       : 3-bit pixel colour
//   COLOR_GREEN   : drawing colour after reset
//   COLOR_BG      : background colour written by a canvas clear
//   XMAX_DEF/YMAX_DEF : default last valid column/row
package paint_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PAINT = 2'd1,
    CLEAR = 2'd2
  } paint_state_t;

  typedef logic [2:0] color_t;

  localparam color_t      COLOR_GREEN = 3'b010;
  localparam color_t      COLOR_BG    = 3'b000;
  localparam int unsigned XMAX_DEF    = 159;
  localparam int unsigned YMAX_DEF    = 119;

endpackage

// File: rtl/canvas_sweep.sv
// Raster x/y counter used to sweep the canvas during a clear.
//   clk, reset_n : clock, asynchronous active-low reset
//   i_start      : restart at (0,0)
//   i_adv        : step one pixel; x wraps at XMAX and bumps y
//   o_x, o_y     : current pixel
//   o_done       : current pixel is (XMAX,YMAX)
module canvas_sweep #(
  parameter int unsigned XMAX = 159,
  parameter int unsigned YMAX = 119
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic       i_adv,
  output logic [7:0] o_x,
  output logic [7:0] o_y,
  output logic       o_done
);

  logic [7:0] r_x;
  logic [7:0] r_y;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_start) begin
      r_x <= '0;
      r_y <= '0;
    end else if (i_adv) begin
      if (r_x == 8'(XMAX)) begin
        r_x <= '0;
        r_y <= r_y + 8'd1;
      end else begin
        r_x <= r_x + 8'd1;
      end
    end
  end

  assign o_x    = r_x;
  assign o_y    = r_y;
  assign o_done = (r_x == 8'(XMAX)) && (r_y == 8'(YMAX));

endmodule

// File: rtl/paint_controller.sv
// Sequences frame-buffer writes from decoded SPI drawing events.
//   clk, reset_n          : clock, asynchronous active-low reset
//   evt_valid/evt_ready   : event handshake; evt_conf selects config vs position
//   evt_brush, evt_color  : config payload (2x2 brush flag, colour)
//   evt_x, evt_y          : position payload
//   clear_req             : single-cycle canvas clear request
//   fb_we/fb_ready        : frame-buffer write handshake
//   fb_x, fb_y, fb_data   : write address and colour
//   cur_brush, cur_color  : current drawing configuration
//   busy                  : not idle, or a clear is pending
//   drop_cnt              : saturating count of out-of-range position events
module paint_controller
  import paint_pkg::*;
#(
  parameter int unsigned XMAX      = XMAX_DEF,
  parameter int unsigned YMAX      = YMAX_DEF,
  parameter color_t      COLOR_RST = COLOR_GREEN,
  parameter color_t      BG_COLOR  = COLOR_BG
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       evt_valid,
  output logic       evt_ready,
  input  logic       evt_conf,
  input  logic       evt_brush,
  input  logic [2:0] evt_color,
  input  logic [7:0] evt_x,
  input  logic [7:0] evt_y,
  input  logic       clear_req,
  output logic       fb_we,
  input  logic       fb_ready,
  output logic [7:0] fb_x,
  output logic [7:0] fb_y,
  output logic [2:0] fb_data,
  output logic       cur_brush,
  output logic [2:0] cur_color,
  output logic       busy,
  output logic [7:0] drop_cnt
);

  paint_state_t r_state;
  logic         r_cur_brush;
  color_t       r_cur_color;
  logic         r_pbrush;
  logic [7:0]   r_base_x;
  logic [7:0]   r_base_y;
  logic [1:0]   r_off;
  logic         r_fb_we;
  logic [7:0]   r_fb_x;
  logic [7:0]   r_fb_y;
  color_t       r_fb_data;
  logic [7:0]   r_drop_cnt;
  logic         r_clear_pend;

  logic         w_evt_ready;
  logic         w_evt_acc;
  logic         w_evt_in_range;
  logic [1:0]   w_noff;
  logic [8:0]   w_nx;
  logic [8:0]   w_ny;
  logic         w_nclip;
  logic         w_paint_last;
  logic         w_sw_start;
  logic         w_sw_adv;
  logic [7:0]   w_sw_x;
  logic [7:0]   w_sw_y;
  logic         w_sw_done;

  assign w_evt_ready    = (r_state == IDLE) && !clear_req && !r_clear_pend;
  assign w_evt_acc      = evt_valid && w_evt_ready;
  assign w_evt_in_range = (evt_x <= 8'(XMAX)) && (evt_y <= 8'(YMAX));

  // Offset index k walks (0,0),(1,0),(0,1),(1,1): dx = k[0], dy = k[1].
  // Next pixel is computed 9 bits wide so base+1 past 255 still clips.
  assign w_noff       = r_off + 2'd1;
  assign w_nx         = {1'b0, r_base_x} + {8'd0, w_noff[0]};
  assign w_ny         = {1'b0, r_base_y} + {8'd0, w_noff[1]};
  assign w_nclip      = (w_nx > 9'(XMAX)) || (w_ny > 9'(YMAX));
  assign w_paint_last = !r_pbrush || (r_off == 2'd3);

  assign w_sw_start = (r_state == IDLE) && (clear_req || r_clear_pend);
  assign w_sw_adv   = (r_state == CLEAR) && fb_ready;

  canvas_sweep #(
    .XMAX (XMAX),
    .YMAX (YMAX)
  ) u_sweep (
    .clk     (clk),
    .reset_n (reset_n),
    .i_start (w_sw_start),
    .i_adv   (w_sw_adv),
    .o_x     (w_sw_x),
    .o_y     (w_sw_y),
    .o_done  (w_sw_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cur_brush  <= 1'b1;
      r_cur_color  <= COLOR_RST;
      r_pbrush     <= 1'b0;
      r_base_x     <= '0;
      r_base_y     <= '0;
      r_off        <= '0;
      r_fb_we      <= 1'b0;
      r_fb_x       <= '0;
      r_fb_y       <= '0;
      r_fb_data    <= '0;
      r_drop_cnt   <= '0;
      r_clear_pend <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (clear_req || r_clear_pend) begin
            r_state      <= CLEAR;
            r_clear_pend <= 1'b0;
            r_fb_we      <= 1'b1;
            r_fb_data    <= BG_COLOR;
          end else if (w_evt_acc) begin
            if (evt_conf) begin
              r_cur_brush <= evt_brush;
              r_cur_color <= evt_color;
            end else if (!w_evt_in_range) begin
              if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
            end else begin
              // Offset (0,0) of an in-range base can never clip.
              r_state   <= PAINT;
              r_base_x  <= evt_x;
              r_base_y  <= evt_y;
              r_pbrush  <= r_cur_brush;
              r_off     <= '0;
              r_fb_x    <= evt_x;
              r_fb_y    <= evt_y;
              r_fb_data <= r_cur_color;
              r_fb_we   <= 1'b1;
            end
          end
        end

        PAINT: begin
          if (clear_req) r_clear_pend <= 1'b1;
          // A clipped offset (fb_we low) moves on without waiting for fb_ready.
          if (!r_fb_we || fb_ready) begin
            if (w_paint_last) begin
              r_state <= IDLE;
              r_fb_we <= 1'b0;
            end else begin
              r_off   <= w_noff;
              r_fb_x  <= w_nx[7:0];
              r_fb_y  <= w_ny[7:0];
              r_fb_we <= !w_nclip;
            end
          end
        end

        CLEAR: begin
          if (fb_ready && w_sw_done) begin
            r_state <= IDLE;
            r_fb_we <= 1'b0;
            r_fb_x  <= 8'(XMAX);
            r_fb_y  <= 8'(YMAX);
          end
        end

        default: begin
          r_state <= IDLE;
          r_fb_we <= 1'b0;
        end
      endcase
    end
  end

  // During CLEAR the write address is the sweep counter itself.
  assign fb_x      = (r_state == CLEAR) ? w_sw_x : r_fb_x;
  assign fb_y      = (r_state == CLEAR) ? w_sw_y : r_fb_y;
  assign fb_we     = r_fb_we;
  assign fb_data   = r_fb_data;
  assign evt_ready = w_evt_ready;
  assign cur_brush = r_cur_brush;
  assign cur_color = r_cur_color;
  assign busy      = (r_state != IDLE) || r_clear_pend;
  assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_paint_controller.sv
// Self-checking bench for paint_controller: directed scenarios plus random
// events, scored against a pixel-list reference model.
module tb_paint_controller;

  localparam int XM = 159;
  localparam int YM = 119;

  logic       clk;
  logic       reset_n;
  logic       evt_valid;
  logic       evt_ready;
  logic       evt_conf;
  logic       evt_brush;
  logic [2:0] evt_color;
  logic [7:0] evt_x;
  logic [7:0] evt_y;
  logic       clear_req;
  logic       fb_we;
  logic       fb_ready;
  logic [7:0] fb_x;
  logic [7:0] fb_y;
  logic [2:0] fb_data;
  logic       cur_brush;
  logic [2:0] cur_color;
  logic       busy;
  logic [7:0] drop_cnt;

  paint_controller dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_conf  (evt_conf),
    .evt_brush (evt_brush),
    .evt_color (evt_color),
    .evt_x     (evt_x),
    .evt_y     (evt_y),
    .clear_req (clear_req),
    .fb_we     (fb_we),
    .fb_ready  (fb_ready),
    .fb_x      (fb_x),
    .fb_y      (fb_y),
    .fb_data   (fb_data),
    .cur_brush (cur_brush),
    .cur_color (cur_color),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: expected write list {clear_tag, x, y, colour}.
  logic [19:0] exp_q[$];
  bit          m_brush;
  logic [2:0]  m_color;
  int          m_drop;
  bit          m_clear_out;
  int unsigned n_writes;
  int          ready_mode;   // 0: always ready, 1: toggle, 2: random
  bit          tgl;
  bit          accepted;
  bit          stall_prev;
  logic [19:0] stall_vals;

  task automatic model_reset();
    exp_q.delete();
    m_brush     = 1'b1;
    m_color     = 3'b010;
    m_drop      = 0;
    m_clear_out = 1'b0;
    stall_prev  = 1'b0;
  endtask

  task automatic model_clear();
    for (int y = 0; y <= YM; y++)
      for (int x = 0; x <= XM; x++)
        exp_q.push_back({1'b1, 8'(x), 8'(y), 3'b000});
    m_clear_out = 1'b1;
  endtask

  task automatic model_event();
    int px;
    int py;
    if (evt_conf) begin
      m_brush = evt_brush;
      m_color = evt_color;
    end else if (int'(evt_x) > XM || int'(evt_y) > YM) begin
      if (m_drop < 255) m_drop++;
    end else begin
      for (int dy = 0; dy < 2; dy++)
        for (int dx = 0; dx < 2; dx++)
          if (m_brush || (dx == 0 && dy == 0)) begin
            px = int'(evt_x) + dx;
            py = int'(evt_y) + dy;
            if (px <= XM && py <= YM) exp_q.push_back({1'b0, 8'(px), 8'(py), m_color});
          end
    end
  endtask

  // One clock: drive fb_ready, observe mid-cycle, then return at posedge+1.
  task automatic tick();
    logic [19:0] e;
    case (ready_mode)
      0: fb_ready = 1'b1;
      1: begin tgl = ~tgl; fb_ready = tgl; end
      default: fb_ready = 1'($urandom_range(0, 1));
    endcase
    accepted = 1'b0;
    @(negedge clk);
    check("cur_brush", cur_brush, m_brush);
    check("cur_color", cur_color, m_color);
    check("drop_cnt", drop_cnt, m_drop);
    if (stall_prev) check("stall_hold", {fb_we, fb_x, fb_y, fb_data}, stall_vals);
    if (exp_q.size() != 0) check("busy_pending", busy, 1);
    if (exp_q.size() != 0 || clear_req) check("ready_low", evt_ready, 0);
    if (clear_req && !m_clear_out) model_clear();
    if (evt_valid && evt_ready) begin
      model_event();
      accepted = 1'b1;
    end
    if (fb_we && fb_ready) begin
      n_writes++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {fb_x, fb_y, fb_data}, 32'hFFFFFFFF);
      end else begin
        e = exp_q.pop_front();
        check("write", {fb_x, fb_y, fb_data}, e[18:0]);
        if (e[19] && e[18:11] == 8'(XM) && e[10:3] == 8'(YM)) m_clear_out = 1'b0;
      end
    end
    stall_prev = fb_we && !fb_ready;
    stall_vals = {fb_we, fb_x, fb_y, fb_data};
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit conf, input bit brush, input logic [2:0] col,
                      input logic [7:0] x, input logic [7:0] y);
    bit done;
    done      = 1'b0;
    evt_valid = 1'b1;
    evt_conf  = conf;
    evt_brush = brush;
    evt_color = col;
    evt_x     = x;
    evt_y     = y;
    for (int i = 0; i < 40000 && !done; i++) begin
      tick();
      done = accepted;
    end
    evt_valid = 1'b0;
    if (!done) check("evt_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40000 && !done; i++) begin
      if (exp_q.size() == 0 && !busy && evt_ready) done = 1'b1;
      else tick();
    end
    if (!done) check("drain_timeout", 0, 1);
  endtask

  int unsigned w0;
  bit          found;

  initial begin
    reset_n    = 1'b0;
    evt_valid  = 1'b0;
    evt_conf   = 1'b0;
    evt_brush  = 1'b0;
    evt_color  = '0;
    evt_x      = '0;
    evt_y      = '0;
    clear_req  = 1'b0;
    fb_ready   = 1'b1;
    ready_mode = 0;
    tgl        = 1'b0;
    n_writes   = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) tick();

    // 1: reset state
    check("rst_color", cur_color, 3'b010);
    check("rst_brush", cur_brush, 1);
    check("rst_fb_we", fb_we, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", evt_ready, 1);
    check("rst_drop", drop_cnt, 0);

    // 2: 1x1 paint latency
    send(1, 0, 3'd5, 0, 0);
    w0 = n_writes;
    send(0, 0, 0, 8'd10, 8'd20);
    check("lat_we", fb_we, 1);
    check("lat_pix", {fb_x, fb_y, fb_data}, {8'd10, 8'd20, 3'd5});
    check("lat_ready_low", evt_ready, 0);
    tick();
    check("lat_ready_back", evt_ready, 1);
    check("lat_we_off", fb_we, 0);
    drain();
    check("w_1x1", n_writes - w0, 1);

    // 3: corner clipping and out-of-range drop
    send(1, 1, 3'd3, 0, 0);
    w0 = n_writes;
    send(0, 0, 0, 8'd159, 8'd119);
    drain();
    check("w_corner", n_writes - w0, 1);
    w0 = n_writes;
    send(0, 0, 0, 8'd200, 8'd5);
    drain();
    check("w_drop", n_writes - w0, 0);
    check("drop_one", drop_cnt, 1);

    // 4: 2x2 with stalling write port
    ready_mode = 1;
    w0 = n_writes;
    send(0, 0, 0, 8'd4, 8'd4);
    drain();
    check("w_2x2", n_writes - w0, 4);
    ready_mode = 0;

    // 5: clear beats a simultaneous event
    w0 = n_writes;
    evt_valid = 1'b1; evt_conf = 1'b0; evt_x = 8'd7; evt_y = 8'd8;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    check("clr_first_busy", busy, 1);
    send(0, 0, 0, 8'd7, 8'd8);
    check("clr_before_evt", n_writes - w0, 19200);
    drain();
    check("w_clear_evt", n_writes - w0, 19204);

    // clear requested during PAINT is serviced before the next event
    w0 = n_writes;
    send(1, 1, 3'd6, 0, 0);
    send(0, 0, 0, 8'd30, 8'd40);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    send(0, 0, 0, 8'd1, 8'd1);
    drain();
    check("w_pend_clear", n_writes - w0, 19208);

    // random events with random write-port stalls
    ready_mode = 2;
    for (int n = 0; n < 250; n++) begin
      send(($urandom_range(0, 3) == 0), 1'($urandom), 3'($urandom),
           8'($urandom_range(0, 175)), 8'($urandom_range(0, 130)));
      repeat ($urandom_range(0, 2)) tick();
    end
    drain();
    check("rand_color", cur_color, m_color);
    check("rand_drops", drop_cnt, m_drop);

    // drop counter saturation
    ready_mode = 0;
    for (int n = 0; n < 260; n++) send(0, 0, 0, 8'd250, 8'($urandom_range(0, 255)));
    drain();
    check("drop_sat", drop_cnt, 255);

    // 6: asynchronous reset mid-clear
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      if (fb_we && fb_x == 8'd50 && fb_y == 8'd3) found = 1'b1;
      else tick();
    end
    check("reach_50_3", found, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_we", fb_we, 0);
    check("async_busy", busy, 0);
    check("async_ready", evt_ready, 1);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    w0 = n_writes;
    repeat (50) tick();
    check("no_write_after_rst", n_writes - w0, 0);
    check("post_rst_color", cur_color, 3'b010);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
